// File: rtl/rocc_accum_unit.sv
// rocc_accum_unit: RoCC-attached bank of NUM_ACC accumulators supporting
// write, read, accumulate, add-twice and clear, one response per command.
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   i_cmd_bits_*            command payload (funct selects op, rs2 selects acc)
//   o_cmd_ready, i_cmd_fire command handshake (accepted only when idle)
//   o_busy                  command in flight
//   o_resp_valid/_bits_*    response channel, i_resp_fire completes it
module rocc_accum_unit #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned NUM_ACC  = 4,
  parameter int unsigned SATURATE = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  i_cmd_bits_inst_opcode,
  input  logic [6:0]  i_cmd_bits_inst_funct,
  input  logic [63:0] i_cmd_bits_rs1,
  input  logic        i_cmd_bits_inst_xs1,
  input  logic [63:0] i_cmd_bits_rs2,
  input  logic        i_cmd_bits_inst_xs2,
  input  logic [4:0]  i_cmd_bits_inst_rd,
  input  logic        i_cmd_bits_inst_xd,
  output logic        o_cmd_ready,
  input  logic        i_cmd_fire,
  output logic        o_busy,
  output logic        o_resp_valid,
  output logic [4:0]  o_resp_bits_rd,
  output logic [63:0] o_resp_bits_data,
  input  logic        i_resp_fire
);

  localparam int unsigned IDX_W = $clog2(NUM_ACC);

  localparam logic [6:0] F_WRITE    = 7'd0;
  localparam logic [6:0] F_READ     = 7'd1;
  localparam logic [6:0] F_ACCUM    = 7'd2;
  localparam logic [6:0] F_ADDTWICE = 7'd3;
  localparam logic [6:0] F_CLEAR    = 7'd4;

  typedef enum logic [1:0] {IDLE, EXEC1, EXEC2, RESP} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   acc [NUM_ACC];
  logic [6:0]         funct_q;
  logic [WIDTH-1:0]   rs1_q;
  logic [IDX_W-1:0]   idx_q;
  logic [4:0]         rd_q;
  logic               xd_q;
  logic [WIDTH-1:0]   resp_data;
  logic [WIDTH-1:0]   acc_sel;
  logic [WIDTH-1:0]   sum;

  // Opcode/xs fields are decoded upstream; upper operand bits are don't-care.
  logic unused_bits;
  assign unused_bits = ^{i_cmd_bits_inst_opcode, i_cmd_bits_inst_xs1,
                         i_cmd_bits_inst_xs2, i_cmd_bits_rs1, i_cmd_bits_rs2};

  // One WIDTH+1 bit addition; carry either dropped or saturates to all-ones.
  function automatic logic [WIDTH-1:0] add_step(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (SATURATE != 0 && s[WIDTH]) return '1;
    return s[WIDTH-1:0];
  endfunction

  assign acc_sel = acc[idx_q];
  assign sum     = add_step(acc_sel, rs1_q);

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_cmd_fire) state_n = EXEC1;
      EXEC1: begin
        if (funct_q == F_ADDTWICE) state_n = EXEC2;
        else if (xd_q)             state_n = RESP;
        else                       state_n = IDLE;
      end
      EXEC2:   state_n = xd_q ? RESP : IDLE;
      RESP:    if (i_resp_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Command capture, accumulator writeback and response data
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
      funct_q   <= '0;
      rs1_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      xd_q      <= 1'b0;
      resp_data <= '0;
    end else begin
      if (state == IDLE && i_cmd_fire) begin
        funct_q <= i_cmd_bits_inst_funct;
        rs1_q   <= i_cmd_bits_rs1[WIDTH-1:0];
        idx_q   <= i_cmd_bits_rs2[IDX_W-1:0];
        rd_q    <= i_cmd_bits_inst_rd;
        xd_q    <= i_cmd_bits_inst_xd;
      end
      if (state == EXEC1) begin
        case (funct_q)
          F_WRITE: begin
            acc[idx_q] <= rs1_q;
            resp_data  <= acc_sel;
          end
          F_READ:     resp_data <= acc_sel;
          F_ACCUM: begin
            acc[idx_q] <= sum;
            resp_data  <= sum;
          end
          F_ADDTWICE: acc[idx_q] <= sum;
          F_CLEAR: begin
            for (int i = 0; i < NUM_ACC; i++) acc[i] <= '0;
            resp_data <= '0;
          end
          default:    resp_data <= '0;
        endcase
      end
      // Second ADDTWICE step reads back the first step's result from acc.
      if (state == EXEC2) begin
        acc[idx_q] <= sum;
        resp_data  <= sum;
      end
    end
  end

  assign o_cmd_ready      = (state == IDLE);
  assign o_busy           = (state != IDLE);
  assign o_resp_valid     = (state == RESP);
  assign o_resp_bits_rd   = rd_q;
  assign o_resp_bits_data = 64'(resp_data);

endmodule

// File: doc/rocc_accum_unit.md
# rocc_accum_unit

RoCC-attached accumulator engine that generalises the single-function add-twice accelerator. It provides NUM_ACC architectural accumulators of WIDTH bits each and executes write, read, accumulate, add-twice and clear commands. It sits behind the RoCC command and response channels of a Rocket tile, and the Chisel BlackBox wrapper drives the fire strobes. A command is accepted only when the unit is idle; the unit then returns at most one response per command.

## Interface
- WIDTH, 64: accumulator and operand width, 8..64. Operands use rs1[WIDTH-1:0]; results are zero-extended to 64 bits.
- NUM_ACC, 4: number of accumulators, power of two, ≥2. IDX_W = clog2(NUM_ACC).
- SATURATE, 0: 0 = arithmetic wraps modulo 2^WIDTH; 1 = unsigned saturation at 2^WIDTH-1.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- i_cmd_bits_inst_opcode  in  7  ignored; decoding is done upstream.
- i_cmd_bits_inst_funct  in  7  operation select.
- i_cmd_bits_rs1  in  64  operand data.
- i_cmd_bits_inst_xs1  in  1  ignored.
- i_cmd_bits_rs2  in  64  accumulator index, taken from rs2[IDX_W-1:0]; upper bits are ignored.
- i_cmd_bits_inst_xs2  in  1  ignored.
- i_cmd_bits_inst_rd  in  5  response destination register.
- i_cmd_bits_inst_xd  in  1  response requested.
- o_cmd_ready  out  1  unit can accept a command.
- i_cmd_fire  in  1  command handshake (valid & ready).
- o_busy  out  1  a command is in flight.
- o_resp_valid  out  1  response valid.
- o_resp_bits_rd  out  5  captured rd.
- o_resp_bits_data  out  64  result, zero-extended.
- i_resp_fire  in  1  response handshake.

## Operation
- Funct codes:
  - 0 WRITE: acc[i] = rs1. Response data = old acc[i].
  - 1 READ: no state change. Response data = acc[i].
  - 2 ACCUM: acc[i] = acc[i] + rs1. Response data = new acc[i].
  - 3 ADDTWICE: acc[i] = acc[i] + rs1 + rs1, performed as two sequential additions. Response data = new value.
  - 4 CLEAR: all accumulators set to 0. Response data = 0.
  - Any other funct: no state change. Response data = 0.
- FSM states and transitions:
  - IDLE → EXEC1 on i_cmd_fire. funct, rs1 (truncated to WIDTH), index, rd and xd are captured on that edge.
  - EXEC1 → EXEC2 when funct = 3.
  - EXEC1 → RESP otherwise, when xd = 1.
  - EXEC1 → IDLE otherwise, when xd = 0.
  - EXEC2 → RESP when xd = 1; EXEC2 → IDLE when xd = 0.
  - RESP → IDLE on i_resp_fire.
- Accumulator writeback:
  - EXEC1 performs the write for funct 0, 2, 3 (the first addition for funct 3) and 4.
  - EXEC2 performs the second addition for funct 3.
  - The response data register is loaded on the final EXEC cycle.
- Arithmetic:
  - Each addition is computed at WIDTH+1 bits.
  - With SATURATE = 0 the carry is dropped.
  - With SATURATE = 1 a carry out forces the result to all-ones.
  - For ADDTWICE, saturation is applied after each step.
- Decoded output signals:
  - o_cmd_ready = (state == IDLE).
  - o_busy = (state != IDLE).
  - o_resp_valid = (state == RESP).
- o_resp_bits_rd and o_resp_bits_data stay stable for the whole time o_resp_valid is high.

## Timing
- Reset values:
  - State IDLE.
  - All accumulators 0.
  - o_cmd_ready = 1, o_busy = 0, o_resp_valid = 0.
  - o_resp_bits_rd = 0, o_resp_bits_data = 0.
- Latency, for a fire at edge T:
  - Single-step functs: o_resp_valid is high from cycle T+2.
  - ADDTWICE: o_resp_valid is high from cycle T+3.
  - With xd = 0, o_cmd_ready returns high at T+2 (single-step) or T+3 (ADDTWICE).
- Peak throughput with xd = 1 and i_resp_fire tied high is one command per 3 cycles.
- i_cmd_fire is ignored unless state is IDLE.
- i_resp_fire is ignored unless state is RESP.
- The next command cannot be accepted in the same cycle as i_resp_fire, because ready rises one cycle later.
- A reset asserted in any state has the following effect on the next edge:
  - Any pending response is discarded.
  - All accumulators are cleared.
  - The FSM returns to IDLE.
- Index wrap: rs2 = NUM_ACC + k addresses acc[k].

## Test plan
- Reset release with WIDTH=32, NUM_ACC=4: o_cmd_ready=1, o_busy=0, o_resp_valid=0. Then READ with rs2=2 and xd=1 → data 0; o_resp_valid rises 2 cycles after fire.
- WRITE acc1=0x10 (xd=0), then ACCUM rs1=0x5 on idx1 with rd=7 → o_resp_bits_rd=7, data 0x15. Verify data holds while i_resp_fire stays low for 5 cycles.
- ADDTWICE rs1=3 on acc0=0 → data 6, with o_resp_valid 3 cycles after fire.
- Wrap versus saturate, WIDTH=8: acc=0xF0, ACCUM rs1=0x20.
  - SATURATE=0 → 0x10.
  - SATURATE=1 → 0xFF.
  - ADDTWICE with rs1=0x90 on 0 under SATURATE=1 → 0xFF.
- Index wrap and unknown funct:
  - WRITE with rs2=5 then READ with rs2=1 → same value.
  - funct=9 → data 0; a following READ shows all accumulators unchanged.
- Reset in RESP, and CLEAR:
  - Assert reset while o_resp_valid=1 → next cycle o_resp_valid=0, and all accumulators read 0.
  - CLEAR with xd=0 → ready returns 2 cycles after fire.
